// File: rtl/imem_arb_init_pkg.sv
// Shared types for the imem_arb_init front end: FSM encoding, requester id,
// read-tag format and the round-robin pick used by the arbiter.
package imem_arb_init_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int ID_W       = 1;
  localparam int RD_LAT_DEF = 3;

  typedef logic [ID_W-1:0] id_t;

  // One entry of the read-return pipeline, also reused to describe a grant.
  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  // Round-robin between two requesters: on contention the one that did not
  // win last time goes first.
  function automatic tag_t rr_pick(input logic vld0, input logic vld1, input id_t last_gnt);
    tag_t g;
    g.vld = vld0 | vld1;
    if (vld0 && vld1) begin
      g.id = ~last_gnt;
    end else if (vld1) begin
      g.id = id_t'(1);
    end else begin
      g.id = id_t'(0);
    end
    return g;
  endfunction

endpackage

// File: rtl/imem_arb_init_if.sv
// Bundle of the two requester ports, their read-return ports and the RAM port.
// slave = the arbiter side, master = requesters plus RAM model.
interface imem_arb_init_if #(
    parameter int ADDRBIT = 11,
    parameter int WIDTH   = 32
);

  logic               req0_vld;
  logic               req0_rdy;
  logic               req0_we;
  logic [ADDRBIT-1:0] req0_a;
  logic [WIDTH-1:0]   req0_di;

  logic               req1_vld;
  logic               req1_rdy;
  logic               req1_we;
  logic [ADDRBIT-1:0] req1_a;
  logic [WIDTH-1:0]   req1_di;

  logic               rsp0_vld;
  logic [WIDTH-1:0]   rsp0_do;
  logic               rsp1_vld;
  logic [WIDTH-1:0]   rsp1_do;

  logic [ADDRBIT-1:0] mem_a;
  logic               mem_we;
  logic               mem_re;
  logic [WIDTH-1:0]   mem_di;
  logic [WIDTH-1:0]   mem_do;

  modport slave (
    input  req0_vld, req0_we, req0_a, req0_di,
    input  req1_vld, req1_we, req1_a, req1_di,
    output req0_rdy, req1_rdy,
    output rsp0_vld, rsp0_do, rsp1_vld, rsp1_do,
    output mem_a, mem_we, mem_re, mem_di,
    input  mem_do
  );

  modport master (
    output req0_vld, req0_we, req0_a, req0_di,
    output req1_vld, req1_we, req1_a, req1_di,
    input  req0_rdy, req1_rdy,
    input  rsp0_vld, rsp0_do, rsp1_vld, rsp1_do,
    input  mem_a, mem_we, mem_re, mem_di,
    output mem_do
  );

endinterface

// File: rtl/imem_arb_init_rd_tagpipe.sv
// RD_LAT-deep shift register of {valid, id} tags that tracks each read through
// the RAM so its data word can be steered back to the requester that issued it.
module imem_rd_tagpipe
  import imem_arb_init_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  tag_t push,
    output tag_t pop
);

  tag_t sr [RD_LAT];

  // NOTE: unlike data-only storage, this array is reset: a stale valid bit
  // would raise a response that was never requested.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) sr[i] <= '0;
    end else begin
      sr[0] <= push;
      for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
    end
  end

  assign pop = sr[RD_LAT-1];

endmodule

// File: rtl/imem_arb_init.sv
// Front end for one single-port RAM: zero-sweep after reset/clr, then
// round-robin sharing between two requesters with tagged read returns.
module imem_arb_init
  import imem_arb_init_pkg::*;
#(
    parameter int ADDRBIT = 11,
    parameter int DEPTH   = 1536,
    parameter int WIDTH   = 32,
    parameter int RD_LAT  = RD_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    output logic            init_done,
    imem_arb_init_if.slave  bus
);

  // DEPTH need not be a power of two, so the sweep stops at DEPTH-1 explicitly.
  localparam logic [ADDRBIT-1:0] LAST_ADDR = ADDRBIT'(DEPTH - 1);

  state_t             st, st_nxt;
  logic [ADDRBIT-1:0] cnt, cnt_nxt;
  id_t                last_gnt;
  tag_t               gnt;
  tag_t               push, pop;

  logic [ADDRBIT-1:0] a_q;
  logic [WIDTH-1:0]   di_q;
  logic [ADDRBIT-1:0] mem_a_c;
  logic [WIDTH-1:0]   mem_di_c;
  logic               mem_we_c;
  logic               mem_re_c;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    gnt      = '0;
    mem_a_c  = a_q;
    mem_di_c = di_q;
    mem_we_c = 1'b0;
    mem_re_c = 1'b0;

    case (st)
      ST_INIT: begin
        mem_we_c = 1'b1;
        mem_a_c  = cnt;
        mem_di_c = '0;
        if (clr) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_ADDR) begin
          cnt_nxt = '0;
          st_nxt  = ST_RUN;
        end else begin
          cnt_nxt = cnt + ADDRBIT'(1);
        end
      end

      ST_RUN: begin
        gnt = rr_pick(bus.req0_vld, bus.req1_vld, last_gnt);
        if (gnt.vld) begin
          if (gnt.id == id_t'(0)) begin
            mem_a_c  = bus.req0_a;
            mem_di_c = bus.req0_di;
            mem_we_c = bus.req0_we;
          end else begin
            mem_a_c  = bus.req1_a;
            mem_di_c = bus.req1_di;
            mem_we_c = bus.req1_we;
          end
          mem_re_c = ~mem_we_c;
        end
        if (clr) begin
          st_nxt  = ST_INIT;
          cnt_nxt = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_INIT;
      cnt      <= '0;
      last_gnt <= id_t'(1);
      a_q      <= '0;
      di_q     <= '0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      a_q  <= mem_a_c;
      di_q <= mem_di_c;
      if (gnt.vld) last_gnt <= gnt.id;
    end
  end

  // Reads push a live tag; writes and idle cycles push a bubble.
  assign push.vld = gnt.vld & ~mem_we_c;
  assign push.id  = gnt.id;

  imem_rd_tagpipe #(
    .RD_LAT (RD_LAT)
  ) u_tagpipe (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop)
  );

  // The reset state is INIT, which would otherwise drive a write during rst.
  assign bus.mem_a  = mem_a_c;
  assign bus.mem_di = mem_di_c;
  assign bus.mem_we = mem_we_c & ~rst;
  assign bus.mem_re = mem_re_c & ~rst;

  assign bus.req0_rdy = gnt.vld & (gnt.id == id_t'(0));
  assign bus.req1_rdy = gnt.vld & (gnt.id == id_t'(1));

  assign bus.rsp0_vld = pop.vld & (pop.id == id_t'(0));
  assign bus.rsp1_vld = pop.vld & (pop.id == id_t'(1));
  assign bus.rsp0_do  = bus.mem_do;
  assign bus.rsp1_do  = bus.mem_do;

  assign init_done = (st == ST_RUN);

endmodule

// File: tb/tb_imem_arb_init.sv
// Directed bench for imem_arb_init with a 3-cycle registered-in/registered-out
// RAM model; inputs change 1 time unit after posedge, outputs are checked at negedge.
module tb_imem_arb_init;

  localparam int ADDRBIT = 11;
  localparam int DEPTH   = 1536;
  localparam int WIDTH   = 32;
  localparam int RD_LAT  = 3;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic init_done;

  imem_arb_init_if #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH)) bus ();

  imem_arb_init #(
    .ADDRBIT (ADDRBIT),
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // RAM model: input register, array access, output register.
  logic [WIDTH-1:0]   ram [0:(1<<ADDRBIT)-1];
  logic               s1_we, s1_re;
  logic [ADDRBIT-1:0] s1_a;
  logic [WIDTH-1:0]   s1_di, s2_q, out_q;
  logic               pre_we;
  logic [ADDRBIT-1:0] pre_a;
  logic [WIDTH-1:0]   pre_d;

  always @(posedge clk) begin
    s1_we <= bus.mem_we;
    s1_re <= bus.mem_re;
    s1_a  <= bus.mem_a;
    s1_di <= bus.mem_di;
    if (s1_we)  ram[s1_a]  <= s1_di;
    if (pre_we) ram[pre_a] <= pre_d;
    if (s1_re)  s2_q <= ram[s1_a];
    out_q <= s2_q;
  end
  assign bus.mem_do = out_q;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.req0_vld = 1'b0; bus.req0_we = 1'b0; bus.req0_a = '0; bus.req0_di = '0;
    bus.req1_vld = 1'b0; bus.req1_we = 1'b0; bus.req1_a = '0; bus.req1_di = '0;
  endtask

  task automatic single(input int id, input logic we, input int a, input logic [WIDTH-1:0] d);
    idle_reqs();
    if (id == 0) begin
      bus.req0_vld = 1'b1; bus.req0_we = we; bus.req0_a = ADDRBIT'(a); bus.req0_di = d;
    end else begin
      bus.req1_vld = 1'b1; bus.req1_we = we; bus.req1_a = ADDRBIT'(a); bus.req1_di = d;
    end
  endtask

  task automatic preload(input int a, input logic [WIDTH-1:0] d);
    pre_we = 1'b1; pre_a = ADDRBIT'(a); pre_d = d;
    next();
    pre_we = 1'b0;
  endtask

  // Entered at the start of sweep cycle 'first'; returns at the start of 'last_excl'.
  // Both requesters hold reads throughout to show no grant leaks out.
  task automatic sweep_chk(input int first, input int last_excl);
    logic [ADDRBIT-1:0] ea;
    bus.req0_vld = 1'b1; bus.req0_we = 1'b0; bus.req0_a = ADDRBIT'(3);
    bus.req1_vld = 1'b1; bus.req1_we = 1'b0; bus.req1_a = ADDRBIT'(4);
    for (int i = first; i < last_excl; i++) begin
      ea = ADDRBIT'(i);
      @(negedge clk);
      check("sweep", {init_done, bus.req0_rdy, bus.req1_rdy, bus.mem_we, bus.mem_re, bus.mem_a, bus.mem_di},
                     {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ea, 32'h0});
      next();
    end
    idle_reqs();
  endtask

  task automatic rd_chk(input int id, input int a, input logic [WIDTH-1:0] d);
    single(id, 1'b0, a, '0);
    @(negedge clk);
    check("rd_gnt", {bus.req0_rdy, bus.req1_rdy, bus.mem_re, bus.mem_a},
                    {id == 0, id == 1, 1'b1, ADDRBIT'(a)});
    next();
    idle_reqs();
    for (int c = 1; c < RD_LAT; c++) begin
      @(negedge clk);
      check("rd_wait", {bus.rsp0_vld, bus.rsp1_vld}, 2'b00);
      next();
    end
    @(negedge clk);
    check("rd_rsp", {bus.rsp0_vld, bus.rsp1_vld, (id == 0) ? bus.rsp0_do : bus.rsp1_do},
                    {id == 0, id == 1, d});
    next();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDRBIT-1:0] ea;
    logic [WIDTH-1:0]   ed;
    int                 gid;

    rst = 1'b1; clr = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    idle_reqs();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {init_done, bus.mem_we, bus.mem_re, bus.rsp0_vld, bus.rsp1_vld}, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full sweep after reset.
    sweep_chk(0, DEPTH);
    @(negedge clk);
    check("init_done", {init_done, bus.mem_we, bus.mem_re}, 3'b100);
    next();

    preload(5, 32'hA5);
    preload(9, 32'h99);

    // Both requesters read continuously: grants alternate starting with 0.
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        bus.req0_vld = 1'b1; bus.req0_we = 1'b0; bus.req0_a = ADDRBIT'(5);
        bus.req1_vld = 1'b1; bus.req1_we = 1'b0; bus.req1_a = ADDRBIT'(9);
      end else begin
        idle_reqs();
      end
      @(negedge clk);
      if (k < 8) begin
        ea = (k % 2 == 0) ? ADDRBIT'(5) : ADDRBIT'(9);
        check("rr_gnt", {bus.req0_rdy, bus.req1_rdy, bus.mem_re, bus.mem_we, bus.mem_a},
                        {k % 2 == 0, k % 2 == 1, 1'b1, 1'b0, ea});
      end
      if (k >= RD_LAT) begin
        gid = (k - RD_LAT) % 2;
        ed  = (gid == 0) ? 32'hA5 : 32'h99;
        check("rr_rsp", {bus.rsp0_vld, bus.rsp1_vld, (gid == 0) ? bus.rsp0_do : bus.rsp1_do},
                        {gid == 0, gid == 1, ed});
      end else begin
        check("rr_norsp", {bus.rsp0_vld, bus.rsp1_vld}, 2'b00);
      end
      next();
    end

    // Only requester 1, ten back-to-back writes.
    for (int i = 0; i < 10; i++) begin
      ea = ADDRBIT'(20 + i);
      ed = 32'h100 + i;
      single(1, 1'b1, 20 + i, ed);
      @(negedge clk);
      check("wr_only", {bus.req0_rdy, bus.req1_rdy, bus.mem_we, bus.mem_re, bus.mem_a, bus.mem_di},
                       {1'b0, 1'b1, 1'b1, 1'b0, ea, ed});
      next();
    end

    // Write then read of the same address on consecutive cycles.
    single(1, 1'b1, 7, 32'h1234);
    @(negedge clk);
    check("wr7", {bus.req1_rdy, bus.mem_we, bus.mem_a, bus.mem_di}, {1'b1, 1'b1, ADDRBIT'(7), 32'h1234});
    next();
    single(1, 1'b0, 7, '0);
    @(negedge clk);
    check("rd7_gnt", {bus.req1_rdy, bus.mem_re, bus.mem_we, bus.mem_a}, {1'b1, 1'b1, 1'b0, ADDRBIT'(7)});
    next();
    idle_reqs();
    @(negedge clk);
    check("idle_hold", {bus.mem_we, bus.mem_re, bus.req0_rdy, bus.req1_rdy, bus.mem_a}, {4'b0, ADDRBIT'(7)});
    next();
    @(negedge clk);
    check("rd7_wait", {bus.rsp0_vld, bus.rsp1_vld}, 2'b00);
    next();
    @(negedge clk);
    check("rd7_rsp", {bus.rsp0_vld, bus.rsp1_vld, bus.rsp1_do}, {1'b0, 1'b1, 32'h1234});
    next();

    rd_chk(0, 25, 32'h105);

    // Read, then clr: response still delivered while the new sweep runs.
    single(0, 1'b0, 5, '0);
    @(negedge clk);
    check("clr_rd_gnt", {bus.req0_rdy, bus.mem_re}, 2'b11);
    next();
    idle_reqs();
    clr = 1'b1;
    @(negedge clk);
    check("clr_cycle", {init_done, bus.rsp0_vld, bus.rsp1_vld}, 3'b100);
    next();
    clr = 1'b0;
    @(negedge clk);
    check("clr_sweep0", {init_done, bus.mem_we, bus.mem_a, bus.rsp0_vld, bus.rsp1_vld},
                        {1'b0, 1'b1, ADDRBIT'(0), 2'b00});
    next();
    @(negedge clk);
    check("clr_rsp", {bus.rsp0_vld, bus.rsp1_vld, bus.rsp0_do, bus.mem_we, bus.mem_a},
                     {2'b10, 32'hA5, 1'b1, ADDRBIT'(1)});
    next();
    sweep_chk(2, DEPTH);
    @(negedge clk);
    check("clr_done", init_done, 1'b1);
    next();

    // rst in the middle of a sweep.
    clr = 1'b1;
    next();
    clr = 1'b0;
    sweep_chk(0, 700);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst", {init_done, bus.mem_we, bus.mem_re}, 3'b000);
    next();
    @(negedge clk);
    check("mid_rst2", {init_done, bus.mem_we, bus.mem_re}, 3'b000);
    next();
    rst = 1'b0;
    sweep_chk(0, DEPTH);
    @(negedge clk);
    check("rst_done", init_done, 1'b1);
    next();

    // rst with two reads in flight: nothing comes back.
    preload(5, 32'hA5);
    preload(9, 32'h99);
    single(0, 1'b0, 5, '0);
    @(negedge clk);
    check("fl_gnt0", {bus.req0_rdy, bus.req1_rdy}, 2'b10);
    next();
    single(1, 1'b0, 9, '0);
    @(negedge clk);
    check("fl_gnt1", {bus.req0_rdy, bus.req1_rdy}, 2'b01);
    next();
    idle_reqs();
    rst = 1'b1;
    @(negedge clk);
    check("fl_rst", {bus.rsp0_vld, bus.rsp1_vld, init_done}, 3'b000);
    next();
    rst = 1'b0;
    for (int c = 0; c < RD_LAT + 3; c++) begin
      @(negedge clk);
      check("fl_none", {bus.rsp0_vld, bus.rsp1_vld, dut.u_tagpipe.pop.vld}, 3'b000);
      next();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arb_init.md
Name: imem_arb_init

Overview:
- Front-end controller for one wrapped single-port RAM (imemspx-style: registered inputs, registered output).
- After reset, or on a clear request, a sweep engine writes zero to every location.
- After that, two requesters share the one RAM port under round-robin arbitration.
- Read returns are tagged through a latency-matched pipeline so each read data word goes back to the requester that issued it.

Parameters:
- ADDRBIT, 11, RAM address width.
- DEPTH, 1536, number of RAM words; need not be a power of two.
- WIDTH, 32, data width.
- RD_LAT, 3, cycles from mem_re driven to valid mem_do. This is 3 for the wrapped RAM.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  single-cycle pulse; restarts the zero-sweep.
- init_done  out  1  high when the RAM is initialised and arbitration is running.
- req0_vld / req1_vld  in  1  request valid.
- req0_rdy / req1_rdy  out  1  request accepted this cycle (combinational grant).
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_a / req1_a  in  ADDRBIT  address.
- req0_di / req1_di  in  WIDTH  write data.
- rsp0_vld / rsp1_vld  out  1  read data valid, one-cycle pulse.
- rsp0_do / rsp1_do  out  WIDTH  read data; valid only when the matching rsp_vld is high.
- mem_a  out  ADDRBIT  RAM address.
- mem_we  out  1  RAM write enable.
- mem_re  out  1  RAM read enable.
- mem_di  out  WIDTH  RAM write data.
- mem_do  in  WIDTH  RAM read data.

Behaviour:
- States: INIT, RUN. Reset state is INIT.
- Reset values: cnt=0, last_gnt=1 (requester 0 has first priority), read pipeline empty, init_done=0, all rsp_vld=0.
- INIT:
  - Drives mem_we=1, mem_re=0, mem_a=cnt, mem_di=0 every cycle. Both rdy are 0.
  - cnt increments by 1 each cycle.
  - When cnt==DEPTH-1: that write is issued, cnt returns to 0, and the next state is RUN.
  - The terminal compare is against DEPTH-1, not 2^ADDRBIT-1.
  - The sweep therefore takes exactly DEPTH cycles. init_done rises on the cycle RUN is entered.
- RUN: init_done=1. Arbitration each cycle:
  - Only one vld high: grant that requester.
  - Both high: grant the requester that is not last_gnt.
  - last_gnt updates only on a grant; no update on idle cycles.
  - Granted request drives mem_a, mem_di, mem_we=we, mem_re=~we.
  - No grant: mem_we=0, mem_re=0; mem_a and mem_di hold their last value.
  - rdy is high only for the granted requester. A request transfers on vld&rdy.
  - Back-to-back grants are allowed, one per cycle with no bubbles.
- Read return:
  - Each granted read pushes {valid=1, id} into an RD_LAT-deep shift register. Writes push valid=0.
  - At the pipeline output: rsp<id>_vld=1 and rsp<id>_do=mem_do. The other requester's rsp_vld stays 0.
  - Latency from a read's vld&rdy cycle to its rsp_vld is exactly RD_LAT cycles.
  - Responses return in issue order.
- clr in RUN:
  - INIT is entered next cycle and cnt restarts at 0.
  - Reads already in the pipeline still complete and are delivered.
  - No new grants are issued during INIT.
- clr in INIT: cnt restarts at 0 and the sweep starts over.
- Write then read to the same address on consecutive cycles: the read returns the new data. The RAM port is sequential, so no forwarding logic is needed.
- rst asserted at any time: immediate return to the reset state. The pipeline is flushed and in-flight responses are dropped. The sweep restarts after rst deasserts.

Decomposition:
- Shared package: state encoding (ST_INIT, ST_RUN), requester id width (1), default RD_LAT=3.
- One natural sub-module: imem_rd_tagpipe, the RD_LAT-deep {valid, id} shift register with reset flush.

Test Plan:
- Reset then release (DEPTH=1536): mem_we=1 with mem_a=0..1535 on consecutive cycles and mem_di=0. init_done=1 on cycle 1536. rdy stays 0 throughout the sweep.
- Both requesters issue continuous reads to a0=5 and a1=9 (RAM preloaded 5:0xA5, 9:0x99): grants alternate 0,1,0,1 starting with 0. rsp0_vld/rsp1_vld alternate 3 cycles after each grant with data 0xA5 and 0x99.
- Only req1 valid for 10 cycles: req1_rdy=1 on all 10 cycles; 10 writes are issued with no gaps. Follow with a req1 read of address 7 after a write of 0x1234 to 7 → rsp1_do=0x1234.
- Read issued one cycle before a clr pulse: the response is still delivered 3 cycles after the grant. A new 1536-cycle sweep follows, and init_done=0 during it.
- rst pulsed at sweep cycle 700: mem_we=0 during reset. After release the sweep restarts at address 0 and init_done is reached 1536 cycles later.
- rst pulsed while 2 reads are in flight: no rsp_vld appears after reset, and the pipeline is empty.
